dnu_hd_packer: RTL and testbench
================================

DNU_HD_PACKER -- requirements
Module: dnu_hd_packer

Interface
REQ-001 SHALL have parameter OUT_WIDTH, default 16, output word width in bits; must be even and at least 4.
REQ-002 SHALL have parameter FRAME_CYCLES, default 383, number of valid input cycles per frame; each cycle carries 2 bits.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, number of output FIFO word entries; must be a power of 2.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 read_clk  input  1  sole clock; all logic samples on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 hd_in_valid  input  1  dnu0/dnu1 hard decisions are valid this cycle.
REQ-008 dnu0_hard_decision  input  1  lane-0 decoded bit from the DNU stage.
REQ-009 dnu1_hard_decision  input  1  lane-1 decoded bit from the DNU stage.
REQ-010 read_addr_offset  input  1  multi-frame selector; becomes the frame tag.
REQ-011 hd_word  output  OUT_WIDTH  packed decoded bits at the FIFO head.
REQ-012 hd_valid  output  1  FIFO is non-empty; hd_word is valid.
REQ-013 hd_last  output  1  hd_word is the final word of its frame.
REQ-014 hd_frame_id  output  1  frame tag of hd_word.
REQ-015 hd_ready  input  1  downstream accepts the word; a pop occurs when hd_valid and hd_ready are both high.
REQ-016 overflow_err  output  1  sticky flag; set when a completed word is dropped.

Function
REQ-017 SHALL pack lane0 into bit 2k and lane1 into bit 2k+1, where k = 0 .. OUT_WIDTH/2-1 is the valid-cycle index within the word (LSB first).
REQ-018 SHALL complete a word when k = OUT_WIDTH/2-1 or when the frame cycle count reaches FRAME_CYCLES-1, whichever comes first.
REQ-019 SHALL zero-fill the unused upper bits of a word completed by end-of-frame, and SHALL set that word's last flag to 1.
REQ-020 SHALL sample read_addr_offset as the frame tag on the first valid cycle of each frame; changes to read_addr_offset mid-frame SHALL be ignored.
REQ-021 SHALL push a completed word, with its last flag and tag, into the FIFO at the clock edge that ends the completing cycle, so hd_valid rises in the next cycle when the FIFO was empty.
REQ-022 SHALL present the FIFO head directly on hd_word, hd_last and hd_frame_id, with no extra register stage.
REQ-023 SHALL hold hd_word, hd_last and hd_frame_id stable while hd_valid=1 and hd_ready=0.
REQ-024 SHALL perform a simultaneous push and pop when the FIFO is full, leaving the count unchanged and dropping no data.
REQ-025 SHALL drop a completed word when the FIFO is full and no pop occurs in that cycle, and SHALL set overflow_err; frame and word counters SHALL still advance.
REQ-026 SHALL ignore a hd_ready that arrives while the FIFO is empty.
REQ-027 SHALL leave all state unchanged on cycles where hd_in_valid=0.
REQ-028 SHALL wrap the frame cycle counter to 0 after FRAME_CYCLES-1, and SHALL start the next frame with k=0.

Reset
REQ-029 SHALL, on rst assertion, immediately clear: hd_valid=0, hd_word=0, hd_last=0, hd_frame_id=0, overflow_err=0, both FIFO pointers, the FIFO count, k, the frame counter and the partial word.
REQ-030 SHALL discard any partial word and all FIFO contents on a mid-frame reset; after reset release, packing SHALL start a fresh frame.
REQ-031 SHALL clear overflow_err only by reset.

Structure
REQ-032 SHALL keep the parameter-derived widths (the k counter width, the frame counter width and the FIFO pointer width) in a shared package.
REQ-033 SHALL implement the FIFO as one sub-module, hd_word_fifo, with push/pop/full/empty ports and a payload of OUT_WIDTH+2 bits.

Verification
REQ-034 Packing test, with OUT_WIDTH=16, FRAME_CYCLES=10, 10 valid cycles of lane0=1, lane1=0, tag=1: the bench SHALL see word0 = 0x5555 with last=0 and tag=1, then word1 = 0x0005 with last=1 and tag=1.
REQ-035 Backpressure test, with hd_ready=0 until 4 words are queued (FIFO_DEPTH=4): the bench SHALL see the 5th completed word dropped, overflow_err=1, and the first 4 words popped intact in order.
REQ-036 Full push/pop test, with the FIFO full, hd_ready=1 and a word completing in the same cycle: the bench SHALL see the count stay at 4 and overflow_err stay 0.
REQ-037 Tag test, with read_addr_offset toggling 0->1 in frame cycle 3: every word of the frame SHALL carry tag=0, and the next frame SHALL carry tag=1.
REQ-038 Gap test, with hd_in_valid deasserted for 5 cycles mid-word: the bench SHALL see the same word content as with no gaps.
REQ-039 Reset test, with rst asserted mid-frame with 2 words queued: all outputs SHALL read 0, and the first post-reset word SHALL reflect post-reset input only.

Source files
------------

// File: rtl/dnu_hd_packer_pkg.sv
// Shared sizing helpers for the hard-decision packer: every width that depends
// on a module parameter is derived here so the top and the FIFO stay in step.
package dnu_hd_packer_pkg;

  localparam int DEF_OUT_WIDTH    = 16;
  localparam int DEF_FRAME_CYCLES = 383;
  localparam int DEF_FIFO_DEPTH   = 4;

  // Never return a zero-width vector, even for degenerate parameter values.
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int k_width(input int out_width);
    return clog2_min1(out_width / 2);
  endfunction

  function automatic int frame_cnt_width(input int frame_cycles);
    return clog2_min1(frame_cycles);
  endfunction

  function automatic int ptr_width(input int depth);
    return clog2_min1(depth);
  endfunction

endpackage

// File: rtl/dnu_hd_packer_fifo.sv
// Small show-ahead word FIFO: the head entry is visible combinationally, and a
// push into a full FIFO is accepted only when a pop happens in the same cycle.
module hd_word_fifo
  import dnu_hd_packer_pkg::*;
#(
  parameter int WIDTH = DEF_OUT_WIDTH + 2,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = ptr_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW:0]      count_reg;
  logic             push_en;
  logic             pop_en;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == (PW+1)'(DEPTH));
  assign pop_en    = pop && !empty;
  assign push_en   = push && (!full || pop_en);
  // Masked to zero while empty so the outputs read 0 straight out of reset.
  assign head_data = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_en)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/dnu_hd_packer.sv
// Packs the two-lane DNU hard decisions into OUT_WIDTH-bit words, tags each
// frame with read_addr_offset and queues finished words for downstream.
module dnu_hd_packer
  import dnu_hd_packer_pkg::*;
#(
  parameter int OUT_WIDTH    = DEF_OUT_WIDTH,
  parameter int FRAME_CYCLES = DEF_FRAME_CYCLES,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                 read_clk,
  input  logic                 rst,
  input  logic                 hd_in_valid,
  input  logic                 dnu0_hard_decision,
  input  logic                 dnu1_hard_decision,
  input  logic                 read_addr_offset,
  output logic [OUT_WIDTH-1:0] hd_word,
  output logic                 hd_valid,
  output logic                 hd_last,
  output logic                 hd_frame_id,
  input  logic                 hd_ready,
  output logic                 overflow_err
);

  localparam int HALF = OUT_WIDTH / 2;
  localparam int KW   = k_width(OUT_WIDTH);
  localparam int FW   = frame_cnt_width(FRAME_CYCLES);

  logic [KW-1:0]        k_reg;
  logic [FW-1:0]        frame_cnt_reg;
  logic [OUT_WIDTH-1:0] word_reg;
  logic                 tag_reg;
  logic                 overflow_reg;

  logic [OUT_WIDTH-1:0] word_next;
  logic                 tag_cur;
  logic                 end_of_frame;
  logic                 word_done;
  logic                 push;
  logic                 fifo_full;
  logic                 fifo_empty;

  always_comb begin
    end_of_frame = (frame_cnt_reg == FW'(FRAME_CYCLES - 1));
    word_done    = (k_reg == KW'(HALF - 1)) || end_of_frame;
    // The tag is live on the first cycle of a frame, then frozen in tag_reg.
    tag_cur      = (frame_cnt_reg == '0) ? read_addr_offset : tag_reg;
    word_next    = word_reg;
    word_next[2 * int'(k_reg)]     = dnu0_hard_decision;
    word_next[2 * int'(k_reg) + 1] = dnu1_hard_decision;
    push         = hd_in_valid && word_done;
  end

  always_ff @(posedge read_clk or posedge rst) begin
    if (rst) begin
      k_reg         <= '0;
      frame_cnt_reg <= '0;
      word_reg      <= '0;
      tag_reg       <= 1'b0;
      overflow_reg  <= 1'b0;
    end else if (hd_in_valid) begin
      tag_reg <= tag_cur;
      // Clearing the partial word on completion gives the zero-fill for free.
      if (word_done) begin
        k_reg    <= '0;
        word_reg <= '0;
      end else begin
        k_reg    <= k_reg + 1'b1;
        word_reg <= word_next;
      end
      frame_cnt_reg <= end_of_frame ? '0 : frame_cnt_reg + 1'b1;
      // A full FIFO is non-empty, so hd_ready alone decides whether it pops.
      if (push && fifo_full && !hd_ready) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  hd_word_fifo #(
    .WIDTH (OUT_WIDTH + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (read_clk),
    .rst       (rst),
    .push      (push),
    .push_data ({tag_cur, end_of_frame, word_next}),
    .pop       (hd_ready),
    .head_data ({hd_frame_id, hd_last, hd_word}),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign hd_valid     = !fifo_empty;
  assign overflow_err = overflow_reg;

endmodule

// File: tb/tb_dnu_hd_packer.sv
// Bench for dnu_hd_packer: directed table, corner-case sequences and random
// traffic against a frame/word reference model built from queues.
module tb_dnu_hd_packer;

  localparam int W    = 16;
  localparam int FC   = 10;
  localparam int D    = 4;
  localparam int HALF = W / 2;

  logic         read_clk = 1'b0;
  logic         rst = 1'b1;
  logic         hd_in_valid = 1'b0;
  logic         dnu0_hard_decision = 1'b0;
  logic         dnu1_hard_decision = 1'b0;
  logic         read_addr_offset = 1'b0;
  logic [W-1:0] hd_word;
  logic         hd_valid;
  logic         hd_last;
  logic         hd_frame_id;
  logic         hd_ready = 1'b0;
  logic         overflow_err;

  int total = 0;
  int bad = 0;

  dnu_hd_packer #(.OUT_WIDTH(W), .FRAME_CYCLES(FC), .FIFO_DEPTH(D)) dut (
    .read_clk           (read_clk),
    .rst                (rst),
    .hd_in_valid        (hd_in_valid),
    .dnu0_hard_decision (dnu0_hard_decision),
    .dnu1_hard_decision (dnu1_hard_decision),
    .read_addr_offset   (read_addr_offset),
    .hd_word            (hd_word),
    .hd_valid           (hd_valid),
    .hd_last            (hd_last),
    .hd_frame_id        (hd_frame_id),
    .hd_ready           (hd_ready),
    .overflow_err       (overflow_err)
  );

  always #5 read_clk = ~read_clk;

  // Reference model: position in frame, partial word, tag, queued {tag,last,word}.
  int           m_fc = 0;
  logic [W-1:0] m_word = '0;
  logic         m_tag = 1'b0;
  logic         m_ovf = 1'b0;
  logic [W+1:0] m_q[$];

  typedef struct {
    logic         v, d0, d1, off, rdy;
    logic         ev;
    logic [W-1:0] ew;
    logic         el, eid;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("valid", hd_valid, m_q.size() > 0);
    chk("ovf", overflow_err, m_ovf);
    if (m_q.size() > 0) begin
      chk("word", hd_word, m_q[0][W-1:0]);
      chk("last", hd_last, m_q[0][W]);
      chk("id", hd_frame_id, m_q[0][W+1]);
    end
  endtask

  // One clock: drive inputs, predict, advance past the edge, compare.
  task automatic cycle(input logic v, input logic d0, input logic d1,
                       input logic off, input logic rdy);
    logic         done;
    logic [W+1:0] ent;
    logic [W+1:0] gone;
    bit           full;
    bit           pop;
    int           k;
    hd_in_valid = v; dnu0_hard_decision = d0; dnu1_hard_decision = d1;
    read_addr_offset = off; hd_ready = rdy;
    full = (m_q.size() == D);
    pop  = rdy && (m_q.size() > 0);
    done = 1'b0;
    ent  = '0;
    if (v) begin
      if (m_fc == 0) m_tag = off;
      k = m_fc % HALF;
      m_word[2*k]   = d0;
      m_word[2*k+1] = d1;
      if (k == HALF - 1 || m_fc == FC - 1) begin
        done = 1'b1;
        ent  = {m_tag, (m_fc == FC - 1), m_word};
        m_word = '0;
      end
      m_fc = (m_fc + 1) % FC;
    end
    @(posedge read_clk);
    #1;
    if (pop) gone = m_q.pop_front();
    if (done) begin
      if (!full || pop) m_q.push_back(ent);
      else m_ovf = 1'b1;
    end
    check_model();
  endtask

  task automatic rnd_cycle(input logic rdy);
    cycle(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), rdy);
  endtask

  task automatic drain();
    for (int n = 0; n < 2 * D && m_q.size() > 0; n++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("drain_empty", hd_valid, 1'b0);
  endtask

  task automatic align_frame();
    for (int n = 0; n < FC && m_fc != 0; n++) rnd_cycle(1'b1);
    drain();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    hd_in_valid = 1'b0; hd_ready = 1'b0;
    #1;
    chk("rst_valid", hd_valid, 1'b0);
    chk("rst_word", hd_word, '0);
    chk("rst_last", hd_last, 1'b0);
    chk("rst_id", hd_frame_id, 1'b0);
    chk("rst_ovf", overflow_err, 1'b0);
    m_fc = 0; m_word = '0; m_tag = 1'b0; m_ovf = 1'b0; m_q.delete();
    repeat (2) @(posedge read_clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic vec_t mk(input logic v, input logic d0, input logic d1, input logic off,
                              input logic rdy, input logic ev, input logic [W-1:0] ew,
                              input logic el, input logic eid);
    vec_t r;
    r.v = v; r.d0 = d0; r.d1 = d1; r.off = off; r.rdy = rdy;
    r.ev = ev; r.ew = ew; r.el = el; r.eid = eid;
    return r;
  endfunction

  initial begin
    for (int i = 0; i < 7; i++) tbl[i] = mk(1, 1, 0, 1, 0, 0, 16'h0000, 0, 0);
    for (int i = 7; i < 10; i++) tbl[i] = mk(1, 1, 0, 1, 0, 1, 16'h5555, 0, 1);
    tbl[10] = mk(0, 0, 0, 0, 1, 1, 16'h0005, 1, 1);
    tbl[11] = mk(0, 0, 0, 0, 1, 0, 16'h0000, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 1, 0, 16'h0000, 0, 0);

    @(posedge read_clk);
    #1;
    do_reset();

    // Packing: ten cycles of lane0=1, lane1=0, then pop both words.
    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].v, tbl[i].d0, tbl[i].d1, tbl[i].off, tbl[i].rdy);
      chk("tbl_valid", hd_valid, tbl[i].ev);
      if (tbl[i].ev) begin
        chk("tbl_word", hd_word, tbl[i].ew);
        chk("tbl_last", hd_last, tbl[i].el);
        chk("tbl_id", hd_frame_id, tbl[i].eid);
      end
    end

    // Full FIFO with a word completing on a popping cycle: nothing lost.
    for (int n = 0; n < 200; n++) begin
      if (m_q.size() == D && ((m_fc % HALF) == HALF - 1 || m_fc == FC - 1)) break;
      rnd_cycle(1'b0);
    end
    rnd_cycle(1'b1);
    chk("fpp_ovf", overflow_err, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("fpp_cnt3", hd_valid, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("fpp_cnt4", hd_valid, 1'b0);

    // Tag: offset changes in frame cycle 3 must not affect this frame.
    align_frame();
    for (int i = 0; i < FC; i++) cycle(1'b1, 1'($urandom), 1'($urandom), (i >= 3), 1'b0);
    chk("tag_f0w0", hd_frame_id, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("tag_f0w1", hd_frame_id, 1'b0);
    chk("tag_f0w1_last", hd_last, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < HALF; i++) cycle(1'b1, 1'($urandom), 1'($urandom), (i < 3), 1'b0);
    chk("tag_f1w0", hd_frame_id, 1'b1);
    align_frame();

    // Gap: five idle cycles with junk inputs inside a word.
    for (int i = 0; i < HALF; i++) begin
      if (i == 3) for (int g = 0; g < 5; g++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 1'(i % 2), 1'b0, 1'b0);
    end
    chk("gap_valid", hd_valid, 1'b1);
    chk("gap_word", hd_word, 16'hDDDD);
    align_frame();

    // Backpressure: four words queue, the fifth is dropped.
    for (int i = 0; i < 2 * FC + HALF - 1; i++) rnd_cycle(1'b0);
    chk("bp_ovf_pre", overflow_err, 1'b0);
    rnd_cycle(1'b0);
    chk("bp_ovf", overflow_err, 1'b1);
    for (int i = 0; i < D; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp_empty", hd_valid, 1'b0);
    chk("bp_ovf_sticky", overflow_err, 1'b1);

    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom_range(0, 3) != 0));

    // Reset mid-frame with two words queued.
    align_frame();
    for (int i = 0; i < FC + 4; i++) rnd_cycle(1'b0);
    chk("rst_pre_valid", hd_valid, 1'b1);
    do_reset();
    for (int i = 0; i < HALF; i++) cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("post_rst_valid", hd_valid, 1'b1);
    chk("post_rst_word", hd_word, 16'hFFFF);
    chk("post_rst_id", hd_frame_id, 1'b1);
    chk("post_rst_last", hd_last, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
